// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter: mode encodings,
// direction type and the width helper used to size the prescaler phase register.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Bits needed to hold 0..value-1, never less than one so the phase register always exists.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-qualified clock prescaler: emits a step once per PRESCALE enabled cycles,
// holding its phase while enable is low and restarting from zero on clear.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);
  import counter_pkg::*;

  localparam int            PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  // With PRESCALE=1 the phase stays at zero, so every enabled cycle is a step.
  assign step = enable && (phase == LAST);

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate modes, prescaler, parallel load,
// terminal-count pulse and sticky overflow. Define COUNTER_CAPTURE_EN to add a capture register.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
`ifdef COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] capture_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             overflow
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

  logic             step;
  logic             at_bound;
  logic             boundary_step;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_clamped;
  dir_e             dir;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .step  (step)
  );

  assign dir          = dir_e'(up_down);
  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  // Bounds are compared against MAX_COUNT explicitly so a MODULO below 2**WIDTH wraps correctly.
  always_comb begin
    count_next = count;
    at_bound   = 1'b0;
    if (dir == DIR_UP) begin
      if (count >= MAX_COUNT) begin
        at_bound   = 1'b1;
        count_next = (sat_mode == MODE_SAT) ? MAX_COUNT : '0;
      end else begin
        count_next = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        at_bound   = 1'b1;
        count_next = (sat_mode == MODE_SAT) ? '0 : MAX_COUNT;
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  assign boundary_step = step && !load && at_bound;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tc_pulse <= 1'b0;
    end else if (load) begin
      count    <= load_clamped;
      tc_pulse <= 1'b0;
    end else if (step) begin
      count    <= count_next;
      tc_pulse <= at_bound;
    end else begin
      tc_pulse <= 1'b0;
    end
  end

  // A boundary step in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (boundary_step) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef COUNTER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_value <= '0;
    end else if (capture) begin
      capture_value <= count;
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: two counters (PRESCALE=1 and PRESCALE=3) share stimulus and are
// compared every cycle against an arithmetic reference model; directed scenarios then random traffic.
module tb_param_updown_counter;

  localparam int WIDTH  = 4;
  localparam int MODULO = 10;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             up_down;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_ovf;
  logic             capture;
  logic [WIDTH-1:0] count_p1;
  logic [WIDTH-1:0] count_p3;
  logic             tc_p1;
  logic             tc_p3;
  logic             ovf_p1;
  logic             ovf_p3;
`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_p1;
  logic [WIDTH-1:0] cap_p3;
`endif

  int checks;
  int failures;
  int tc_seen;

  int prescale [2] = '{1, 3};
  int m_count  [2];
  int m_phase  [2];
  int m_tc     [2];
  int m_ovf    [2];
  int m_cap    [2];

  param_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
`ifdef COUNTER_CAPTURE_EN
    .capture(capture), .capture_value(cap_p1),
`endif
    .count(count_p1), .tc_pulse(tc_p1), .overflow(ovf_p1)
  );

  param_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
`ifdef COUNTER_CAPTURE_EN
    .capture(capture), .capture_value(cap_p3),
`endif
    .count(count_p3), .tc_pulse(tc_p3), .overflow(ovf_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour: the count lives in 0..MODULO-1, a step happens on every
  // PRESCALE-th enabled cycle, and stepping off either end is a boundary event.
  task automatic updateModel(input bit rst, input bit en, input bit ud, input bit sat,
                             input bit ld, input int lv, input bit clr, input bit cap);
    for (int i = 0; i < 2; i++) begin
      int  old_count;
      bit  stepped;
      bit  bound;
      old_count = m_count[i];
      if (rst) begin
        m_count[i] = 0; m_phase[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_cap[i] = 0;
      end else begin
        if (cap) m_cap[i] = old_count;
        if (ld) begin
          m_count[i] = (lv > MODULO - 1) ? MODULO - 1 : lv;
          m_phase[i] = 0;
          m_tc[i]    = 0;
          if (clr) m_ovf[i] = 0;
        end else begin
          stepped = 0;
          bound   = 0;
          if (en) begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == prescale[i]) begin
              stepped    = 1;
              m_phase[i] = 0;
            end
          end
          if (stepped) begin
            if (ud) begin
              if (old_count == MODULO - 1) begin
                bound = 1;
                m_count[i] = sat ? old_count : 0;
              end else m_count[i] = old_count + 1;
            end else begin
              if (old_count == 0) begin
                bound = 1;
                m_count[i] = sat ? 0 : MODULO - 1;
              end else m_count[i] = old_count - 1;
            end
          end
          m_tc[i] = bound;
          if (bound) m_ovf[i] = 1;
          else if (clr) m_ovf[i] = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit ud, input bit sat,
                               input bit ld, input int lv, input bit clr, input bit cap);
    reset = rst; enable = en; up_down = ud; sat_mode = sat;
    load = ld; load_value = WIDTH'(lv); clear_ovf = clr; capture = cap;
    @(posedge clk);
    updateModel(rst, en, ud, sat, ld, lv, clr, cap);
    #1;
    checkOutput("count_p1", int'(count_p1), m_count[0]);
    checkOutput("tc_p1",    int'(tc_p1),    m_tc[0]);
    checkOutput("ovf_p1",   int'(ovf_p1),   m_ovf[0]);
    checkOutput("count_p3", int'(count_p3), m_count[1]);
    checkOutput("tc_p3",    int'(tc_p3),    m_tc[1]);
    checkOutput("ovf_p3",   int'(ovf_p3),   m_ovf[1]);
`ifdef COUNTER_CAPTURE_EN
    checkOutput("cap_p1", int'(cap_p1), m_cap[0]);
    checkOutput("cap_p3", int'(cap_p3), m_cap[1]);
`endif
    if (tc_p1) tc_seen++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_phase[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_cap[i] = 0;
    end

    // Reset for two cycles, then idle with enable low.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_count", int'(count_p1), 0);
    checkOutput("reset_ovf",   int'(ovf_p1),   0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("idle_count", int'(count_p1), 0);

    // Count up in wrap mode across the 9 -> 0 boundary.
    tc_seen = 0;
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("wrap_count", int'(count_p1), 2);
    checkOutput("wrap_tc_once", tc_seen, 1);
    checkOutput("wrap_ovf", int'(ovf_p1), 1);

    // Count down in saturate mode from 2, then clear the sticky flag.
    applyStimulus(0, 0, 0, 1, 1, 2, 1, 0);
    checkOutput("sat_ovf_cleared_by_load_cycle", int'(ovf_p1), 0);
    tc_seen = 0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("sat_count", int'(count_p1), 0);
    checkOutput("sat_tc_twice", tc_seen, 2);
    checkOutput("sat_ovf", int'(ovf_p1), 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 1, 0);
    checkOutput("sat_set_beats_clear", int'(ovf_p1), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 0);
    checkOutput("clear_ovf", int'(ovf_p1), 0);

    // Load is clamped to MODULO-1 and wins over a simultaneous step.
    applyStimulus(0, 0, 1, 0, 1, 13, 0, 0);
    checkOutput("load_clamp", int'(count_p1), 9);
    applyStimulus(0, 1, 1, 0, 1, 4, 0, 0);
    checkOutput("load_beats_step", int'(count_p1), 4);
    checkOutput("load_no_tc", int'(tc_p1), 0);

    // Prescaled instance: nine enabled cycles give three steps; gaps hold the phase.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("p3_three_steps", int'(count_p3), 3);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("p3_hold", int'(count_p3), 3);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("p3_resume", int'(count_p3), 4);

    // Reset mid-count, and capture of the pre-update count.
    applyStimulus(0, 0, 1, 0, 1, 7, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("mid_reset", int'(count_p1), 0);
    applyStimulus(0, 0, 1, 0, 1, 5, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 1);
`ifdef COUNTER_CAPTURE_EN
    checkOutput("capture_old", int'(cap_p1), 5);
`endif
    checkOutput("capture_cycle_step", int'(count_p1), 6);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
